alu_opnd_entry: RTL and testbench
=================================

# alu_opnd_entry

Operand/command entry sequencer that drives the 4-bit ALU's A, B and op inputs. It debounces two raw push-buttons, steps the user through entering A, then B, then op from board switches, and presents the finished command on a valid/ready handshake. It sits between the board I/O (switches, buttons) and the ALU/display datapath.

## Interface
- DB_CYCLES, 16, consecutive stable cycles a synchronized button level must hold before it is accepted; minimum 2
- CNT_W, $clog2(DB_CYCLES+1), debounce counter width (derived, not overridden)
- clk  in  1  sole clock
- rst_n  in  1  reset, synchronous, active-low
- sw_val  in  4  operand switches, sampled when enter is accepted in S_A/S_B
- sw_op  in  3  op-code switches, same encoding as ALU op (000 add … 111 eq)
- btn_enter  in  1  raw enter button, active-high, asynchronous, bouncy
- btn_clr  in  1  raw clear button, active-high, asynchronous, bouncy
- cmd_ready  in  1  downstream accepts command this cycle
- cmd_a  out  4  operand A
- cmd_b  out  4  operand B
- cmd_op  out  3  operation code
- cmd_valid  out  1  command complete and held stable
- stage  out  2  current state encoding, for LED display

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer: a counter increments while the synchronized level differs from the accepted level and clears when they match. When the counter reaches DB_CYCLES, the accepted level takes the synchronized value on that edge. A press event is a one-cycle pulse on an accepted 0->1 transition. Releases generate no event.
- FSM states: S_A=0, S_B=1, S_OP=2, S_ISSUE=3. stage equals the state.
- S_A + enter event: cmd_a <= sw_val, go to S_B.
- S_B + enter event: cmd_b <= sw_val, go to S_OP.
- S_OP + enter event: cmd_op <= sw_op, go to S_ISSUE.
- S_ISSUE: cmd_valid=1 (a decode of the state). When cmd_valid&&cmd_ready, go to S_A. cmd_a/b/op keep their values, so the last command stays displayed. Enter events in S_ISSUE are discarded; they are not queued.
- Clear event in any state: go to S_A, clear cmd_a/cmd_b/cmd_op to 0, and drop cmd_valid next cycle.
- If clear and enter events occur in the same cycle, clear wins and enter is discarded.
- While cmd_valid=1, cmd_a/b/op must not change until the handshake completes or a clear occurs.
- Switch inputs are used only at capture and are not synchronized; the user holds them static across the press.

## Timing
- Reset (rst_n=0 at a clk edge) sets:
  - state to S_A and stage to 0
  - cmd_a, cmd_b, cmd_op, cmd_valid to 0
  - synchronizer flops, accepted levels and counters to 0
- Reset mid-debounce discards the partial count. A button already held through reset release is accepted DB_CYCLES+2 cycles after release and produces one event.
- Latency: btn_enter rises before edge t. The synchronized level is high after edge t+1. The event pulse is high in the cycle after edge t+1+DB_CYCLES. The captured register or state updates at edge t+2+DB_CYCLES.
- A bounce shorter than DB_CYCLES cycles, in either direction, produces no event and does not disturb the accepted level.
- cmd_valid rises the cycle after the op-capture edge. The handshake completes on the edge where cmd_valid&&cmd_ready. cmd_valid is 0 the following cycle, and the earliest new cmd_valid is three accepted presses later.
- cmd_ready while cmd_valid=0 has no effect.

## Structure
- Shared header alu_defs.vh holds:
  - ALU op-code localparams (OP_ADD=3'b000 … OP_EQ=3'b111)
  - state encodings S_A..S_ISSUE
  - operand width 4 and op width 3
- Sub-module btn_debounce (synchronizer, counter and edge pulse; parameter DB_CYCLES; ports clk, rst_n, raw, level, press) is instantiated twice, for enter and clear.
- The top level holds the FSM and the capture registers only.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset: hold rst_n=0 for 3 cycles with btn_enter toggling -> all outputs 0, stage=0, no event; after release with buttons low, nothing changes for 20 cycles.
- Full entry: press/release enter with sw_val=5, then sw_val=3, then sw_op=3'b001, cmd_ready=0 -> cmd_a=5, cmd_b=3, cmd_op=1, stage=3, cmd_valid=1 held; assert cmd_ready for 1 cycle -> cmd_valid=0 next cycle, stage=0, values retained.
- Bounce: enter pulses of 1, 2 and 3 cycles separated by 1-cycle gaps, then held high for 10 cycles -> exactly one capture, at edge t+6 of the final rise.
- Latency: enter rises before edge 10 and is held -> event cycle after edge 15, cmd_a updated at edge 16.
- Clear: enter A=9 and B=7, then press clear; also clear and enter accepted in the same cycle -> outputs 0, stage=0, and the simultaneous enter is ignored.
- Ignored enter: in S_ISSUE with cmd_ready=0, press enter twice -> outputs unchanged; after the handshake, stage=0 and no phantom capture.

Source files
------------

// File: rtl/alu_opnd_entry_pkg.sv
// Shared definitions for the ALU operand entry block: ALU op codes, entry FSM
// states and datapath widths.
package alu_opnd_entry_pkg;

  localparam int OPND_W = 4;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

  // The encoding doubles as the LED stage display value.
  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_opnd_entry_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-count debouncer and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
  import alu_opnd_entry_pkg::*;
#(
  parameter  int DB_CYCLES = 16,
  localparam int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, count disagreement cycles and accept the new level on the DB_CYCLES-th one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r   <= {CNT_W{1'b0}};
        press_r <= 1'b0;
      end else if (cnt_r == CNT_W'(DB_CYCLES - 1)) begin
        // Releases are accepted too, but only a rising level is a press.
        level_r <= sync2_r;
        cnt_r   <= {CNT_W{1'b0}};
        press_r <= sync2_r;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
        press_r <= 1'b0;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/alu_opnd_entry.sv
// Operand/command entry sequencer: steps through A, B and op capture from the
// board switches and offers the finished command on a valid/ready handshake.
module alu_opnd_entry
  import alu_opnd_entry_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPND_W-1:0] sw_val,
  input  logic [OP_W-1:0]   sw_op,
  input  logic              btn_enter,
  input  logic              btn_clr,
  input  logic              cmd_ready,
  output logic [OPND_W-1:0] cmd_a,
  output logic [OPND_W-1:0] cmd_b,
  output logic [OP_W-1:0]   cmd_op,
  output logic              cmd_valid,
  output logic [1:0]        stage
);

  logic              enter_evt_s;
  logic              clr_evt_s;
  state_t            state_r;
  logic [OPND_W-1:0] cmd_a_r;
  logic [OPND_W-1:0] cmd_b_r;
  logic [OP_W-1:0]   cmd_op_r;
  logic              cmd_valid_r;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_enter),
    .level (),
    .press (enter_evt_s)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clr),
    .level (),
    .press (clr_evt_s)
  );

  // Entry FSM with capture registers; clear outranks any same-cycle enter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_A;
      cmd_a_r     <= {OPND_W{1'b0}};
      cmd_b_r     <= {OPND_W{1'b0}};
      cmd_op_r    <= {OP_W{1'b0}};
      cmd_valid_r <= 1'b0;
    end else if (clr_evt_s) begin
      state_r     <= S_A;
      cmd_a_r     <= {OPND_W{1'b0}};
      cmd_b_r     <= {OPND_W{1'b0}};
      cmd_op_r    <= {OP_W{1'b0}};
      cmd_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_A: begin
          if (enter_evt_s) begin
            cmd_a_r <= sw_val;
            state_r <= S_B;
          end
        end
        S_B: begin
          if (enter_evt_s) begin
            cmd_b_r <= sw_val;
            state_r <= S_OP;
          end
        end
        S_OP: begin
          if (enter_evt_s) begin
            cmd_op_r    <= sw_op;
            state_r     <= S_ISSUE;
            cmd_valid_r <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Operands are held for display after the handshake; enter is dropped here.
          if (cmd_valid_r && cmd_ready) begin
            state_r     <= S_A;
            cmd_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_A;
          cmd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_a     = cmd_a_r;
  assign cmd_b     = cmd_b_r;
  assign cmd_op    = cmd_op_r;
  assign cmd_valid = cmd_valid_r;
  assign stage     = state_r;

endmodule

// File: tb/tb_alu_opnd_entry.sv
// Directed bench for alu_opnd_entry: stimulus pushes expected commands into a
// scoreboard that a negedge monitor checks whenever cmd_valid is presented.
module tb_alu_opnd_entry;

  localparam int DB = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_val;
  logic [2:0] sw_op;
  logic       btn_enter;
  logic       btn_clr;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_valid;
  logic [1:0] stage;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_opnd_entry #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_val    (sw_val),
    .sw_op     (sw_op),
    .btn_enter (btn_enter),
    .btn_clr   (btn_clr),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_valid (cmd_valid),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_enter();
    btn_enter = 1'b1;
    step(DB + 4);
    btn_enter = 1'b0;
    step(DB + 4);
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    step(DB + 4);
    btn_clr = 1'b0;
    step(DB + 4);
  endtask

  task automatic enter_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_q.push_back('{a: a, b: b, op: op});
    sw_val = a; press_enter();
    sw_val = b; press_enter();
    sw_op = op; press_enter();
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
  endtask

  // Scoreboard monitor: pops on each new cmd_valid and tracks stability while held.
  initial begin
    cmd_t cur_exp;
    logic prev_valid;
    logic held_ok;
    prev_valid = 1'b0;
    held_ok    = 1'b1;
    cur_exp    = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (cmd_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            cur_exp = exp_q.pop_front();
            chk("cmd_presented", int'({cmd_a, cmd_b, cmd_op}), int'(cur_exp));
            held_ok = 1'b1;
          end
        end else if (cmd_valid && prev_valid) begin
          if ({cmd_a, cmd_b, cmd_op} != cur_exp) held_ok = 1'b0;
        end else if (!cmd_valid && prev_valid) begin
          chk("cmd_held_stable", int'(held_ok), 1);
        end
        prev_valid = cmd_valid;
      end
    end
  end

  initial begin
    logic quiet_ok;
    rst_n = 1'b0; sw_val = 4'd0; sw_op = 3'd0;
    btn_enter = 1'b0; btn_clr = 1'b0; cmd_ready = 1'b0;

    // Reset with a toggling enter button
    for (int i = 0; i < 3; i++) begin
      btn_enter = ~btn_enter;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("reset_outputs", int'({cmd_a, cmd_b, cmd_op, cmd_valid}), 0);
    chk("reset_stage", int'(stage), 0);
    step(1);
    rst_n = 1'b1; btn_enter = 1'b0;
    quiet_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({cmd_a, cmd_b, cmd_op, cmd_valid, stage} != 14'd0) quiet_ok = 1'b0;
    end
    chk("post_reset_quiet", int'(quiet_ok), 1);
    step(1);

    // Latency: rise before edge t, capture at edge t+DB+2
    sw_val = 4'hA;
    btn_enter = 1'b1;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    chk("latency_a_before", int'(cmd_a), 0);
    chk("latency_stage_before", int'(stage), 0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_a_after", int'(cmd_a), 10);
    chk("latency_stage_after", int'(stage), 1);
    step(4);
    btn_enter = 1'b0;
    step(DB + 4);

    // Bounce: 1,2,3-cycle pulses with 1-cycle gaps, then a held press
    sw_val = 4'h6;
    for (int n = 1; n <= 3; n++) begin
      btn_enter = 1'b1; step(n);
      btn_enter = 1'b0; step(1);
    end
    btn_enter = 1'b1;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    chk("bounce_b_before", int'(cmd_b), 0);
    chk("bounce_stage_before", int'(stage), 1);
    @(posedge clk);
    @(negedge clk);
    chk("bounce_b_after", int'(cmd_b), 6);
    chk("bounce_stage_after", int'(stage), 2);
    step(3);
    btn_enter = 1'b0;
    step(DB + 4);
    exp_q.push_back('{a: 4'hA, b: 4'h6, op: 3'b011});
    sw_op = 3'b011; press_enter();
    handshake();

    // cmd_ready while idle has no effect
    cmd_ready = 1'b1; step(5); cmd_ready = 1'b0;
    @(negedge clk);
    chk("ready_idle_stage", int'(stage), 0);
    step(1);

    // Full entry and handshake
    enter_cmd(4'd5, 4'd3, 3'b001);
    @(negedge clk);
    chk("full_stage_issue", int'(stage), 3);
    step(5);
    @(negedge clk);
    chk("full_valid_held", int'(cmd_valid), 1);
    step(1);
    handshake();
    @(negedge clk);
    chk("full_valid_dropped", int'(cmd_valid), 0);
    chk("full_stage_idle", int'(stage), 0);
    chk("full_retained", int'({cmd_a, cmd_b, cmd_op}), int'({4'd5, 4'd3, 3'b001}));
    step(1);

    // Enter presses in S_ISSUE are discarded
    enter_cmd(4'd2, 4'd4, 3'b110);
    sw_val = 4'hF; sw_op = 3'b111;
    press_enter();
    press_enter();
    @(negedge clk);
    chk("ignored_outputs", int'({cmd_a, cmd_b, cmd_op}), int'({4'd2, 4'd4, 3'b110}));
    chk("ignored_stage", int'(stage), 3);
    step(1);
    handshake();
    step(DB + 6);
    @(negedge clk);
    chk("no_phantom_stage", int'(stage), 0);
    chk("no_phantom_a", int'(cmd_a), 2);
    step(1);

    // Clear after A and B
    sw_val = 4'd9; press_enter();
    sw_val = 4'd7; press_enter();
    @(negedge clk);
    chk("clr_pre_stage", int'(stage), 2);
    step(1);
    press_clr();
    @(negedge clk);
    chk("clr_outputs", int'({cmd_a, cmd_b, cmd_op, cmd_valid}), 0);
    chk("clr_stage", int'(stage), 0);
    step(1);

    // Simultaneous clear and enter: clear wins
    sw_val = 4'd9; press_enter();
    sw_val = 4'hC;
    btn_enter = 1'b1; btn_clr = 1'b1;
    step(DB + 4);
    btn_enter = 1'b0; btn_clr = 1'b0;
    step(DB + 4);
    @(negedge clk);
    chk("simul_outputs", int'({cmd_a, cmd_b, cmd_op}), 0);
    chk("simul_stage", int'(stage), 0);
    step(1);

    // Clear while a command is presented
    enter_cmd(4'd1, 4'd1, 3'b001);
    press_clr();
    @(negedge clk);
    chk("clr_issue_valid", int'(cmd_valid), 0);
    chk("clr_issue_stage", int'(stage), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
